uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, 8N1 frames with stop-bit error flag.
// rx is double-flopped before use; every output is a flop.
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_rx_busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [3:0] MID_TICK = 4'd7;
  localparam logic [3:0] END_TICK = 4'd15;

  state_e               state_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic [3:0]           tick_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;

  // Synchronizer resets to the idle level so no false start follows reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      o_rx_data   <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      o_rx_busy   <= 1'b0;
    end else begin
      o_rx_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q    <= START;
            tick_cnt_q <= '0;
            o_rx_busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt_q == MID_TICK) begin
              if (!rx_s_q) begin
                state_q    <= DATA;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end else begin
                state_q   <= IDLE;
                o_rx_busy <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt_q == END_TICK) begin
              shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
              tick_cnt_q <= '0;
              if (bit_cnt_q == LAST_BIT) begin
                state_q <= STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt_q == END_TICK) begin
              o_rx_data   <= shift_q;
              o_frame_err <= ~rx_s_q;
              o_rx_done   <= 1'b1;
              o_rx_busy   <= 1'b0;
              state_q     <= IDLE;
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          o_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames with baud skew,
// checked against a queue of bytes the serial driver transmitted.
module tb_uart_rx;

  localparam int TICK_DIV = 8;
  localparam int NOM_BIT  = 16 * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rx;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_rx_busy;

  uart_rx #(.DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .rx         (rx),
    .o_rx_data  (o_rx_data),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err),
    .o_rx_busy  (o_rx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // {frame_err, data}
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         got_ticks[$];
  int         dbl_pulse = 0;
  logic       busy_prev = 1'b0;
  logic       done_prev = 1'b0;
  int         tcnt      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    tick = 1'b0;
    forever begin
      for (int i = 0; i < TICK_DIV; i++) begin
        @(negedge clk);
        tick = (i == 0);
      end
    end
  end

  // Collect completed frames and the tick count from START entry to the done edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (busy_prev && tick) tcnt++;
      if (!busy_prev && o_rx_busy) tcnt = 0;
      if (o_rx_done) begin
        got_q.push_back({o_frame_err, o_rx_data});
        got_ticks.push_back(tcnt);
        if (done_prev) dbl_pulse++;
      end
      busy_prev = o_rx_busy;
      done_prev = o_rx_done;
    end
  end

  task automatic idle_line(input int clks);
    rx = 1'b1;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bit_clks, input logic good);
    rx = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bit_clks) @(negedge clk);
    end
    if (good) begin
      rx = 1'b1;
      repeat (bit_clks) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (bit_clks * 3 / 4) @(negedge clk);
      rx = 1'b1;
      repeat (bit_clks - bit_clks * 3 / 4) @(negedge clk);
    end
    exp_q.push_back({~good, b});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (4) @(negedge clk);
    while (o_rx_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle"}, 32'(o_rx_busy), 32'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    check_eq({tag, "_frames"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_data%0d", tag, i), 32'(got_q[i][7:0]), 32'(exp_q[i][7:0]));
      check_eq($sformatf("%s_err%0d", tag, i), 32'(got_q[i][8]), 32'(exp_q[i][8]));
    end
    got_q.delete();
    exp_q.delete();
    got_ticks.delete();
  endtask

  initial begin
    logic [7:0] abort_b;
    logic [7:0] rb;
    int         bc;
    int         t;
    logic       good;

    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_data", 32'(o_rx_data), 32'h00);
    check_eq("rst_done", 32'(o_rx_done), 32'd0);
    check_eq("rst_err", 32'(o_frame_err), 32'd0);
    check_eq("rst_busy", 32'(o_rx_busy), 32'd0);
    rst = 1'b1;
    idle_line(40);
    check_eq("post_rst_busy", 32'(o_rx_busy), 32'd0);

    send_frame(8'hA5, NOM_BIT, 1'b1);
    wait_idle("a5");
    t = (got_ticks.size() > 0) ? got_ticks[0] : -1;
    check_eq("a5_latency_in_range", 32'(t >= 150 && t <= 152), 32'd1);
    drain("a5");
    check_eq("a5_hold", 32'(o_rx_data), 32'hA5);

    rx = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    idle_line(NOM_BIT);
    wait_idle("glitch");
    drain("glitch");
    check_eq("glitch_data_held", 32'(o_rx_data), 32'hA5);

    send_frame(8'h3C, NOM_BIT, 1'b0);
    idle_line(NOM_BIT);
    wait_idle("badstop");
    drain("badstop");
    check_eq("badstop_err_held", 32'(o_frame_err), 32'd1);

    send_frame(8'h00, NOM_BIT, 1'b1);
    send_frame(8'hFF, NOM_BIT, 1'b1);
    wait_idle("b2b");
    drain("b2b");

    rx = 1'b0;
    repeat (1240) @(negedge clk);
    check_eq("break_restart_busy", 32'(o_rx_busy), 32'd1);
    idle_line(NOM_BIT);
    exp_q.push_back({1'b1, 8'h00});
    wait_idle("break");
    drain("break");

    abort_b = 8'h5A;
    rx = 1'b0;
    repeat (NOM_BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = abort_b[i];
      repeat (NOM_BIT) @(negedge clk);
    end
    rx = abort_b[4];
    repeat (NOM_BIT / 2) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("abort_busy_in_rst", 32'(o_rx_busy), 32'd0);
    check_eq("abort_data_in_rst", 32'(o_rx_data), 32'h00);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    idle_line(2 * NOM_BIT);
    check_eq("abort_busy_after", 32'(o_rx_busy), 32'd0);
    send_frame(8'h81, NOM_BIT, 1'b1);
    wait_idle("abort");
    drain("abort");
    check_eq("abort_final_data", 32'(o_rx_data), 32'h81);

    send_frame(8'h55, NOM_BIT - NOM_BIT * 3 / 100, 1'b1);
    idle_line(NOM_BIT);
    send_frame(8'h55, NOM_BIT + NOM_BIT * 3 / 100, 1'b1);
    wait_idle("skew");
    drain("skew");

    for (int k = 0; k < 16; k++) begin
      rb   = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      bc   = good ? (124 + $urandom_range(0, 8)) : NOM_BIT;
      send_frame(rb, bc, good);
      if (!good) idle_line(NOM_BIT);
      idle_line($urandom_range(0, 2) * bc / 2);
    end
    wait_idle("rand");
    drain("rand");

    check_eq("single_cycle_done", 32'(dbl_pulse), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
